// File: rtl/avr_cpu_fetch.sv
// AVR instruction fetch stage: owns the PC, drives synchronous program memory,
// and shares the memory port with LPM byte reads requested by execute.
module avr_cpu_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pmem_addr,
    input  logic [15:0] pmem_data,
    output logic [15:0] opcode,
    output logic        cycle,
    output logic [15:0] pc,
    input  logic [15:0] pc_update,
    input  logic        hold,
    input  logic        lpm_read,
    input  logic [15:0] lpm_addr,
    output logic [7:0]  lpm_data
);

    typedef enum logic {BOOT, RUN} state_t;
    typedef enum logic {SRC_MEM, SRC_REG} src_t;

    state_t      r_state;
    state_t      w_state_next;
    src_t        r_src;
    logic [15:0] r_pc;
    logic [15:0] r_opcode;
    logic        r_cycle;
    logic        r_lpm_pending;
    logic        r_lpm_sel;
    logic [15:0] w_next_pc;

    // Modulo-2^16 add gives PC wrap-around and backward branches for free.
    assign w_next_pc = r_pc + pc_update;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = RUN;
        pmem_addr    = RESET_PC;
        opcode       = 16'h0000;
        cycle        = 1'b0;
        if (r_state == RUN) begin
            opcode = (r_src == SRC_MEM) ? pmem_data : r_opcode;
            cycle  = r_cycle;
            if (!hold) begin
                pmem_addr = w_next_pc;
            end else if (lpm_read) begin
                pmem_addr = {1'b0, lpm_addr[15:1]};
            end else begin
                pmem_addr = r_pc;
            end
        end
    end

    assign pc       = r_pc;
    assign lpm_data = r_lpm_pending ? (r_lpm_sel ? pmem_data[15:8] : pmem_data[7:0]) : 8'h00;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            r_src         <= SRC_MEM;
            r_pc          <= RESET_PC;
            r_opcode      <= 16'h0000;
            r_cycle       <= 1'b0;
            r_lpm_pending <= 1'b0;
            r_lpm_sel     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == RUN) begin
                if (!hold) begin
                    r_pc          <= w_next_pc;
                    r_cycle       <= 1'b0;
                    r_src         <= SRC_MEM;
                    r_lpm_pending <= 1'b0;
                end else begin
                    // Latch the instruction so the port is free for LPM or refetch.
                    r_cycle       <= 1'b1;
                    r_opcode      <= opcode;
                    r_src         <= SRC_REG;
                    r_lpm_pending <= lpm_read;
                    if (lpm_read) begin
                        r_lpm_sel <= lpm_addr[0];
                    end
                end
            end
        end
    end

endmodule
